// File: rtl/lsq_sqn_allocator.sv
// Load/store SqN allocator beside rename: numbers each group, tracks LQ/SQ credits against commit,
// stalls the whole group on overflow or during the one-cycle recovery after a mispredict restore.
module lsq_sqn_allocator #(
  parameter int WIDTH_UOPS = 4,
  parameter int LQ_SIZE    = 16,
  parameter int SQ_SIZE    = 16,
  parameter int SQN_W      = 7,
  parameter int CNT_W      = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        IN_en,
  input  logic [WIDTH_UOPS-1:0]       IN_uopValid,
  input  logic [WIDTH_UOPS-1:0]       IN_uopIsLoad,
  input  logic [WIDTH_UOPS-1:0]       IN_uopIsStore,
  input  logic [CNT_W-1:0]            IN_comLoadCnt,
  input  logic [CNT_W-1:0]            IN_comStoreCnt,
  input  logic                        IN_branchTaken,
  input  logic [SQN_W-1:0]            IN_branchLoadSqN,
  input  logic [SQN_W-1:0]            IN_branchStoreSqN,
  output logic                        OUT_stall,
  output logic [WIDTH_UOPS-1:0]       OUT_uopValid,
  output logic [WIDTH_UOPS*SQN_W-1:0] OUT_loadSqN,
  output logic [WIDTH_UOPS*SQN_W-1:0] OUT_storeSqN,
  output logic [SQN_W-1:0]            OUT_nextLoadSqN,
  output logic [SQN_W-1:0]            OUT_nextStoreSqN
);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  state_t                      r_state, w_state_nxt;
  logic [SQN_W-1:0]            r_alloc_load, r_last_store, r_com_load, r_com_store;
  logic [SQN_W-1:0]            w_alloc_load_nxt, w_last_store_nxt;
  logic [WIDTH_UOPS-1:0]       w_is_load, w_is_store;
  logic [SQN_W-1:0]            w_n_load, w_n_store;
  logic [WIDTH_UOPS*SQN_W-1:0] w_load_sqn, w_store_sqn;
  logic [SQN_W:0]              w_occ_load, w_occ_store;
  logic                        w_lq_ovf, w_sq_ovf, w_accept;

  assign w_is_load  = IN_uopValid & IN_uopIsLoad & ~IN_uopIsStore;
  assign w_is_store = IN_uopValid & IN_uopIsStore;

  // Loads are numbered before counting the slot, stores after: storeSqN is the last store at or before the slot.
  always_comb begin
    w_n_load    = '0;
    w_n_store   = '0;
    w_load_sqn  = '0;
    w_store_sqn = '0;
    for (int i = 0; i < WIDTH_UOPS; i++) begin
      w_load_sqn[i*SQN_W +: SQN_W]  = r_alloc_load + w_n_load;
      w_n_load                      = w_n_load + SQN_W'(w_is_load[i]);
      w_n_store                     = w_n_store + SQN_W'(w_is_store[i]);
      w_store_sqn[i*SQN_W +: SQN_W] = r_last_store + w_n_store;
    end
  end

  // Occupancy is modular in SQN_W bits, then widened so adding the group cannot wrap.
  assign w_occ_load  = {1'b0, r_alloc_load - r_com_load};
  assign w_occ_store = {1'b0, r_last_store + SQN_W'(1) - r_com_store};
  assign w_lq_ovf    = (w_occ_load + {1'b0, w_n_load}) > (SQN_W+1)'(LQ_SIZE);
  assign w_sq_ovf    = (w_occ_store + {1'b0, w_n_store}) > (SQN_W+1)'(SQ_SIZE);

  assign OUT_stall = rst | (r_state == RECOVER) | w_lq_ovf | w_sq_ovf;
  assign w_accept  = IN_en & ~OUT_stall & ~IN_branchTaken & (|IN_uopValid);

  always_comb begin
    w_state_nxt      = RUN;
    w_alloc_load_nxt = r_alloc_load;
    w_last_store_nxt = r_last_store;
    if (IN_branchTaken) begin
      w_state_nxt      = RECOVER;
      w_alloc_load_nxt = IN_branchLoadSqN;
      w_last_store_nxt = IN_branchStoreSqN;
    end else if (w_accept) begin
      w_alloc_load_nxt = r_alloc_load + w_n_load;
      w_last_store_nxt = r_last_store + w_n_store;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alloc_load     <= '0;
      r_last_store     <= '1;
      r_com_load       <= '0;
      r_com_store      <= '0;
      OUT_uopValid     <= '0;
      OUT_loadSqN      <= '0;
      OUT_storeSqN     <= '0;
      OUT_nextLoadSqN  <= '0;
      OUT_nextStoreSqN <= '0;
    end else begin
      r_alloc_load     <= w_alloc_load_nxt;
      r_last_store     <= w_last_store_nxt;
      r_com_load       <= r_com_load + SQN_W'(IN_comLoadCnt);
      r_com_store      <= r_com_store + SQN_W'(IN_comStoreCnt);
      OUT_uopValid     <= w_accept ? IN_uopValid : '0;
      OUT_nextLoadSqN  <= w_alloc_load_nxt;
      OUT_nextStoreSqN <= w_last_store_nxt + SQN_W'(1);
      if (w_accept) begin
        OUT_loadSqN  <= w_load_sqn;
        OUT_storeSqN <= w_store_sqn;
      end
    end
  end

endmodule

// File: doc/lsq_sqn_allocator.md
Name: lsq_sqn_allocator

Overview:
- Allocates load and store sequence numbers (SqNs) to each rename group of up to WIDTH_UOPS uops.
- Tracks load-queue and store-queue occupancy as credits against commit, and stalls the front end when either queue would overflow.
- Restores its allocation pointers on a branch mispredict.
- Sits beside the rename stage; its registered outputs travel alongside the renamed uops into the issue and LSQ path.

Parameters:
- WIDTH_UOPS, 4, uops per rename group.
- LQ_SIZE, 16, load-queue entries (must be ≤ 64).
- SQ_SIZE, 16, store-queue entries (must be ≤ 64).
- SQN_W, 7, width of load/store SqNs; all pointer arithmetic is modulo 2^SQN_W.
- CNT_W, 3, commit-count width; must equal clog2(WIDTH_UOPS+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- IN_en  in  1  downstream ready to accept a group.
- IN_uopValid  in  WIDTH_UOPS  slot valid.
- IN_uopIsLoad  in  WIDTH_UOPS  slot is a load.
- IN_uopIsStore  in  WIDTH_UOPS  slot is a store.
- IN_comLoadCnt  in  CNT_W  loads retired this cycle.
- IN_comStoreCnt  in  CNT_W  stores retired this cycle.
- IN_branchTaken  in  1  mispredict restore strobe.
- IN_branchLoadSqN  in  SQN_W  load pointer to restore.
- IN_branchStoreSqN  in  SQN_W  last valid store SqN to restore.
- OUT_stall  out  1  combinational; group cannot be accepted.
- OUT_uopValid  out  WIDTH_UOPS  registered slot valid.
- OUT_loadSqN  out  WIDTH_UOPS*SQN_W  per-slot load SqN.
- OUT_storeSqN  out  WIDTH_UOPS*SQN_W  per-slot store SqN.
- OUT_nextLoadSqN  out  SQN_W  next load SqN to allocate.
- OUT_nextStoreSqN  out  SQN_W  next store SqN to allocate.

Behaviour:
- **State**
  - allocLoad = next load SqN.
  - lastStore = most recently allocated store SqN.
  - comLoad, comStore = retire pointers.
  - fsm ∈ {RUN, RECOVER}.
- **Reset**
  - allocLoad=0, lastStore=all-ones (−1), comLoad=0, comStore=0, fsm=RUN.
  - OUT_uopValid=0, OUT_loadSqN=0, OUT_storeSqN=0.
  - OUT_nextLoadSqN=0, OUT_nextStoreSqN=0.
  - OUT_stall=1 while rst is high.
- **Classification**
  - A slot is a load if valid && isLoad && !isStore; a store if valid && isStore. isStore wins when both are set.
  - nL and nS are the group popcounts of loads and stores.
- **Occupancy** (modular, SQN_W bits)
  - occL = allocLoad − comLoad.
  - occS = lastStore + 1 − comStore.
- **Stall**
  - OUT_stall = rst | (fsm==RECOVER) | (occL+nL > LQ_SIZE) | (occS+nS > SQ_SIZE).
  - Occupancy is compared at SQN_W+1 bits.
- **Accept**
  - accept = IN_en && !OUT_stall && !IN_branchTaken && |IN_uopValid.
  - Acceptance is all-or-nothing per group; there is no partial acceptance.
- **Per-slot numbering** (latency 1; registered on accept)
  - loadSqN[i] = allocLoad + (number of loads in slots < i).
  - storeSqN[i] = lastStore + (number of stores in slots ≤ i).
  - Non-memory slots still receive both numbers.
  - OUT_uopValid[i] = IN_uopValid[i].
- **Pointer update on accept**
  - allocLoad += nL; lastStore += nS.
- **Not accepted and IN_branchTaken=0**
  - OUT_uopValid=0; pointers and SqN outputs hold.
- **Commit**
  - comLoad += IN_comLoadCnt and comStore += IN_comStoreCnt every non-reset cycle, including stall, RECOVER and branch cycles.
  - A commit takes effect on occupancy the next cycle.
- **Branch** (IN_branchTaken=1, highest priority below rst)
  - allocLoad=IN_branchLoadSqN, lastStore=IN_branchStoreSqN.
  - OUT_uopValid=0; the same-cycle group is dropped.
  - fsm→RECOVER.
- **RECOVER**
  - Forced stall for exactly one cycle, then →RUN.
  - A branch arriving in RECOVER re-restores the pointers and stays in RECOVER one more cycle.
- **Next-SqN outputs** (registered each cycle)
  - OUT_nextLoadSqN = allocLoad_next.
  - OUT_nextStoreSqN = lastStore_next + 1.
- **Wrap-around**
  - All SqNs wrap modulo 2^SQN_W silently.
  - LQ_SIZE, SQ_SIZE ≤ 64 keep occupancy unambiguous.
- **Precondition, not checked**
  - Restored pointers lie within [com pointer, alloc pointer].
  - Commit counts never exceed occupancy.
- **rst asserted mid-operation**
  - Reset values apply on the next edge; in-flight group and commits that cycle are discarded.

Test Plan:
- Reset for 2 cycles, then release -> OUT_nextLoadSqN=0, OUT_nextStoreSqN=0, OUT_uopValid=0, OUT_stall=0 on the first cycle after release.
- From reset, group {L,S,–,L} all valid, IN_en=1 -> next cycle:
  - OUT_loadSqN={0,1,1,1}, OUT_storeSqN={127,0,0,0}, OUT_uopValid=4'b1111.
  - OUT_nextLoadSqN=2, OUT_nextStoreSqN=1.
- Accept 4 groups of 4 loads (occL=16), then present 1 load -> OUT_stall=1 and pointers hold.
  - Pulse IN_comLoadCnt=1 -> OUT_stall=0 the following cycle; that load gets loadSqN=16.
- IN_branchTaken with IN_branchLoadSqN=5, IN_branchStoreSqN=2 while a valid group is presented:
  - Group dropped, OUT_uopValid=0; next cycle OUT_nextLoadSqN=5, OUT_nextStoreSqN=3.
  - OUT_stall=1 for exactly one cycle (RECOVER), then 0.
- Wrap: reach allocLoad=126 with commits keeping occL<12, then accept 4 loads -> OUT_loadSqN={126,127,0,1}, OUT_nextLoadSqN=2, no stall.
- Simultaneous events and reset:
  - IN_en=0 with a valid group plus IN_comStoreCnt=2 -> OUT_uopValid=0, store occupancy drops by 2, alloc pointers unchanged.
  - Then assert rst mid-stream -> all reset values restored.
